// File: rtl/femto_clk_manager_pkg.sv
// Shared state encodings and sizing helpers for the FemtoRV clock manager.
package femto_clk_manager_pkg;

    // FSM state encodings (also exported on the debug state port)
    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_STABILISE = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;
    localparam logic [1:0] ST_LOST      = 2'd3;

    // Number of clk cycles the lock must stay high before release
    function automatic int unsigned stable_cycles(input int unsigned freq_mhz,
                                                  input int unsigned stable_us);
        return freq_mhz * stable_us;
    endfunction

    // Width of a counter able to hold values 0..n
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/femto_clk_manager_if.sv
// Lock input plus reset/strobe/status outputs of the clock manager.
interface femto_clk_manager_if #(
    parameter int unsigned NCHAN      = 2,
    parameter int unsigned LOSS_CNT_W = 8
);
    logic                  pll_locked;
    logic                  sys_reset;
    logic [NCHAN-1:0]      en;
    logic [LOSS_CNT_W-1:0] loss_count;
    logic [1:0]            state;

    // Clock manager side
    modport master (
        input  pll_locked,
        output sys_reset,
        output en,
        output loss_count,
        output state
    );

    // SoC / PLL wrapper side
    modport slave (
        output pll_locked,
        input  sys_reset,
        input  en,
        input  loss_count,
        input  state
    );
endinterface

// File: rtl/femto_clk_manager_nco.sv
// Single NCO channel: phase accumulator with a registered carry strobe.
module femto_nco #(
    parameter int unsigned ACC_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [ACC_W-1:0] inc,
    output logic             en
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    // Accumulator plus increment, carry in the top bit
    always_comb begin
        sum = {1'b0, acc} + {1'b0, inc};
    end

    // Advance while running; otherwise park at zero so the next release ramps from 0
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            en  <= 1'b0;
        end else if (run) begin
            acc <= sum[ACC_W-1:0];
            en  <= sum[ACC_W];
        end else begin
            acc <= '0;
            en  <= 1'b0;
        end
    end

endmodule

// File: rtl/femto_clk_manager.sv
// Post-PLL clock manager: lock qualification, SoC reset release, lock-loss
// counting and NCHAN NCO clock-enable strobes.
module femto_clk_manager
    import femto_clk_manager_pkg::*;
#(
    parameter int unsigned               FREQ_MHZ   = 40,
    parameter int unsigned               STABLE_US  = 10,
    parameter int unsigned               NCHAN      = 2,
    parameter int unsigned               ACC_W      = 24,
    parameter logic [NCHAN*ACC_W-1:0]    INC        = '0,
    parameter int unsigned               LOSS_CNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    femto_clk_manager_if.master bus
);

    localparam int unsigned SC    = stable_cycles(FREQ_MHZ, STABLE_US);
    localparam int unsigned CNT_W = cnt_width(SC);

    logic                  sync_q1;
    logic                  lk_s;
    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic                  sys_reset_q;
    logic                  sys_reset_next;
    logic [LOSS_CNT_W-1:0] loss_q;
    logic [LOSS_CNT_W-1:0] loss_next;
    logic                  run;
    logic [NCHAN-1:0]      en_w;

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            sync_q1 <= bus.pll_locked;
            lk_s    <= sync_q1;
        end
    end

    // State, stable counter, registered reset output and loss counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_WAIT_LOCK;
            cnt         <= '0;
            sys_reset_q <= 1'b1;
            loss_q      <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            sys_reset_q <= sys_reset_next;
            loss_q      <= loss_next;
        end
    end

    // Next-state logic; a lock drop always wins over reaching the count
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        loss_next  = loss_q;
        case (state)
            ST_WAIT_LOCK: begin
                cnt_next = '0;
                if (lk_s) state_next = ST_STABILISE;
            end
            ST_STABILISE: begin
                if (!lk_s) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt == CNT_W'(SC - 1)) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!lk_s) state_next = ST_LOST;
            end
            ST_LOST: begin
                state_next = ST_WAIT_LOCK;
                if (loss_q != '1) loss_next = loss_q + LOSS_CNT_W'(1);
            end
            default: begin
                state_next = ST_WAIT_LOCK;
                cnt_next   = '0;
            end
        endcase
        sys_reset_next = (state_next != ST_RUN);
    end

    assign run = (state == ST_RUN);

    // One NCO per strobe channel
    for (genvar i = 0; i < NCHAN; i++) begin : g_nco
        femto_nco #(
            .ACC_W (ACC_W)
        ) u_nco (
            .clk   (clk),
            .reset (reset),
            .run   (run),
            .inc   (INC[i*ACC_W +: ACC_W]),
            .en    (en_w[i])
        );
    end

    assign bus.sys_reset  = sys_reset_q;
    assign bus.en         = en_w;
    assign bus.loss_count = loss_q;
    assign bus.state      = state;

endmodule
